// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and occupancy width for the elastic pipeline stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int COUNT_W = 2;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one pipeline entry: valid bit, control bits and payload with load/clear enables
module pipe_entry #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] new_ctrl,
  input  logic [DATA_W-1:0] new_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // clear kills valid and control but keeps the payload for the bubble output
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= new_ctrl;
      data  <= new_data;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with optional skid entry, hold and flush
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [CTRL_W-1:0]  ctrl_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [DATA_W-1:0]  data_o,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic [COUNT_W-1:0] count_o
);

  localparam bit HAS_SKID = (SKID != 0);

  state_t               state, state_n;
  logic [COUNT_W-1:0]   count, count_n;
  logic                 push, pop;
  logic                 main_load, main_from_skid, main_clear;
  logic                 skid_load, skid_clear;
  logic                 main_valid, skid_valid;
  logic [CTRL_W-1:0]    main_ctrl, skid_ctrl, main_new_ctrl;
  logic [DATA_W-1:0]    main_data, skid_data, main_new_data;

  assign push = valid_i & ready_o & ~hold_i & ~flush_i;
  assign pop  = valid_o & ready_i;

  assign valid_o = main_valid & ~hold_i;
  assign ctrl_o  = valid_o ? main_ctrl : '0;
  assign data_o  = main_data;
  assign count_o = count;

  always_comb begin
    state_n        = state;
    count_n        = count;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (!hold_i) begin
      if (flush_i) begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
        state_n    = ST_EMPTY;
        count_n    = '0;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (push) begin
              main_load = 1'b1;
              state_n   = ST_FULL;
              count_n   = COUNT_W'(1);
            end
          end
          ST_FULL: begin
            if (push && pop) begin
              main_load = 1'b1;
            end else if (push && HAS_SKID) begin
              skid_load = 1'b1;
              state_n   = ST_SKID;
              count_n   = COUNT_W'(2);
            end else if (pop) begin
              main_clear = 1'b1;
              state_n    = ST_EMPTY;
              count_n    = '0;
            end
          end
          ST_SKID: begin
            // the skid entry is older than anything upstream, so it refills main first
            if (pop && skid_valid) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clear     = 1'b1;
              state_n        = ST_FULL;
              count_n        = COUNT_W'(1);
            end
          end
          default: begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_n    = ST_EMPTY;
            count_n    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_EMPTY;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  assign main_new_ctrl = main_from_skid ? skid_ctrl : ctrl_i;
  assign main_new_data = main_from_skid ? skid_data : data_i;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (main_load),
    .clear    (main_clear),
    .new_ctrl (main_new_ctrl),
    .new_data (main_new_data),
    .valid    (main_valid),
    .ctrl     (main_ctrl),
    .data     (main_data)
  );

  generate
    if (HAS_SKID) begin : g_skid
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (skid_load),
        .clear    (skid_clear),
        .new_ctrl (ctrl_i),
        .new_data (data_i),
        .valid    (skid_valid),
        .ctrl     (skid_ctrl),
        .data     (skid_data)
      );
      // ready depends only on registered state, never on ready_i
      assign ready_o = (state != ST_SKID) & ~hold_i & ~rst_i;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign ready_o    = (~valid_o | ready_i) & ~hold_i;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - vector table, corner sequences and random run against a queue model
module tb_pipe_stage_elastic;

  typedef struct {
    logic        rst, valid, ready, hold, flush;
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic        ev, er;
    logic [7:0]  ec;
    logic [31:0] ed;
    logic [1:0]  en;
  } vec_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0, hold_i = 1'b0, flush_i = 1'b0;
  logic [7:0]  ctrl_i = '0;
  logic [31:0] data_i = '0;

  logic        v_o [2];
  logic        r_o [2];
  logic [7:0]  c_o [2];
  logic [31:0] d_o [2];
  logic [1:0]  n_o [2];

  int checks = 0;
  int errors = 0;

  item_t       mq [2][$];
  logic [31:0] last_data [2];
  logic        ev_s [2];
  logic        er_s [2];
  bit          model_on = 1'b0;

  logic        s0_v;
  logic [31:0] s0_d;
  logic [1:0]  s0_n;

  vec_t tab [23];
  logic [31:0] got [$];

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r_o[0]), .ctrl_i(ctrl_i),
    .data_i(data_i), .valid_o(v_o[0]), .ready_i(ready_i), .ctrl_o(c_o[0]), .data_o(d_o[0]),
    .hold_i(hold_i), .flush_i(flush_i), .count_o(n_o[0])
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r_o[1]), .ctrl_i(ctrl_i),
    .data_i(data_i), .valid_o(v_o[1]), .ready_i(ready_i), .ctrl_o(c_o[1]), .data_o(d_o[1]),
    .hold_i(hold_i), .flush_i(flush_i), .count_o(n_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, valid, ready, hold, flush,
                              input logic [7:0] ctrl, input logic [31:0] data,
                              input logic ev, er, input logic [7:0] ec,
                              input logic [31:0] ed, input logic [1:0] en);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ready = ready; v.hold = hold; v.flush = flush;
    v.ctrl = ctrl; v.data = data; v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.en = en;
    return v;
  endfunction

  // Model: a FIFO of capacity 1 (m=0) or 2 (m=1); outputs derived from its contents.
  task automatic check_models();
    logic ev, er;
    logic [7:0] ec;
    logic [31:0] ed;
    for (int m = 0; m < 2; m++) begin
      ev = (mq[m].size() > 0) && !hold_i;
      ec = ev ? mq[m][0].ctrl : 8'h00;
      ed = (mq[m].size() > 0) ? mq[m][0].data : last_data[m];
      if (m == 1) er = (mq[1].size() < 2) && !hold_i && !rst_i;
      else        er = ((mq[0].size() == 0) || ready_i) && !hold_i;
      ev_s[m] = ev;
      er_s[m] = er;
      if (model_on) begin
        chk($sformatf("model%0d_valid", m), 32'(v_o[m]), 32'(ev));
        chk($sformatf("model%0d_ready", m), 32'(r_o[m]), 32'(er));
        chk($sformatf("model%0d_ctrl", m),  32'(c_o[m]), 32'(ec));
        chk($sformatf("model%0d_data", m),  d_o[m], ed);
        chk($sformatf("model%0d_count", m), 32'(n_o[m]), 32'(mq[m].size()));
      end
    end
  endtask

  task automatic update_models();
    item_t it;
    for (int m = 0; m < 2; m++) begin
      if (rst_i) begin
        mq[m].delete();
        last_data[m] = '0;
      end else if (!hold_i) begin
        if (flush_i) begin
          mq[m].delete();
        end else begin
          if (ev_s[m] && ready_i) void'(mq[m].pop_front());
          if (valid_i && er_s[m]) begin
            it.ctrl = ctrl_i;
            it.data = data_i;
            mq[m].push_back(it);
          end
        end
      end
      if (mq[m].size() > 0) last_data[m] = mq[m][0].data;
    end
    if (rst_i) model_on = 1'b1;
  endtask

  task automatic cycle(input bit use_tab, input vec_t v, input string nm);
    @(negedge clk);
    rst_i = v.rst; valid_i = v.valid; ready_i = v.ready; hold_i = v.hold; flush_i = v.flush;
    ctrl_i = v.ctrl; data_i = v.data;
    #1;
    check_models();
    s0_v = v_o[0]; s0_d = d_o[0]; s0_n = n_o[0];
    if (use_tab) begin
      chk({nm, "_valid"}, 32'(v_o[1]), 32'(v.ev));
      chk({nm, "_ready"}, 32'(r_o[1]), 32'(v.er));
      chk({nm, "_ctrl"},  32'(c_o[1]), 32'(v.ec));
      chk({nm, "_data"},  d_o[1], v.ed);
      chk({nm, "_count"}, 32'(n_o[1]), 32'(v.en));
    end
    @(posedge clk);
    update_models();
  endtask

  initial begin
    vec_t v;
    //            rst v r h f ctrl   data          ev er ec     ed            en
    tab[0]  = mk(1, 0, 0, 0, 0, 8'h00, 32'h0,      0, 0, 8'h00, 32'h0,      0);
    tab[1]  = mk(0, 0, 1, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'h0,      0);
    tab[2]  = mk(0, 1, 1, 0, 0, 8'h5A, 32'h1234,   0, 1, 8'h00, 32'h0,      0);
    tab[3]  = mk(0, 0, 1, 0, 0, 8'h00, 32'h0,      1, 1, 8'h5A, 32'h1234,   1);
    tab[4]  = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'h1234,   0);
    tab[5]  = mk(0, 1, 0, 0, 0, 8'h01, 32'hA,      0, 1, 8'h00, 32'h1234,   0);
    tab[6]  = mk(0, 1, 0, 0, 0, 8'h02, 32'hB,      1, 1, 8'h01, 32'hA,      1);
    tab[7]  = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      1, 0, 8'h01, 32'hA,      2);
    tab[8]  = mk(0, 0, 1, 0, 0, 8'h00, 32'h0,      1, 0, 8'h01, 32'hA,      2);
    tab[9]  = mk(0, 0, 1, 0, 0, 8'h00, 32'h0,      1, 1, 8'h02, 32'hB,      1);
    tab[10] = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'hB,      0);
    tab[11] = mk(0, 1, 0, 0, 0, 8'h33, 32'hCAFE,   0, 1, 8'h00, 32'hB,      0);
    tab[12] = mk(0, 1, 0, 0, 1, 8'h44, 32'hDEAD,   1, 1, 8'h33, 32'hCAFE,   1);
    tab[13] = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'hCAFE,   0);
    tab[14] = mk(0, 0, 1, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'hCAFE,   0);
    tab[15] = mk(0, 1, 0, 0, 0, 8'h77, 32'hBEEF,   0, 1, 8'h00, 32'hCAFE,   0);
    tab[16] = mk(0, 1, 1, 1, 1, 8'h11, 32'h1111,   0, 0, 8'h00, 32'hBEEF,   1);
    tab[17] = mk(0, 1, 1, 1, 1, 8'h11, 32'h1111,   0, 0, 8'h00, 32'hBEEF,   1);
    tab[18] = mk(0, 1, 1, 1, 1, 8'h11, 32'h1111,   0, 0, 8'h00, 32'hBEEF,   1);
    tab[19] = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      1, 1, 8'h77, 32'hBEEF,   1);
    tab[20] = mk(0, 1, 0, 0, 0, 8'h88, 32'h2222,   1, 1, 8'h77, 32'hBEEF,   1);
    tab[21] = mk(1, 0, 0, 0, 0, 8'h00, 32'h0,      1, 0, 8'h77, 32'hBEEF,   2);
    tab[22] = mk(0, 0, 0, 0, 0, 8'h00, 32'h0,      0, 1, 8'h00, 32'h0,      0);

    last_data[0] = '0;
    last_data[1] = '0;
    cycle(1'b0, tab[0], "init");
    for (int i = 0; i < 23; i++) cycle(1'b1, tab[i], $sformatf("vec%0d", i));

    // single-entry stage streaming 0..9 with ready held high
    cycle(1'b0, mk(1, 0, 1, 0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0, 0), "rst");
    for (int k = 0; k <= 10; k++) begin
      v = mk(0, (k < 10), 1, 0, 0, 8'(k + 1), 32'(k), 0, 0, 8'h0, 32'h0, 0);
      cycle(1'b0, v, "stream");
      chk($sformatf("single_valid_c%0d", k), 32'(s0_v), 32'((k >= 1) ? 1 : 0));
      chk($sformatf("single_count_c%0d", k), 32'(s0_n <= 2'd1), 32'd1);
      if (s0_v) got.push_back(s0_d);
    end
    chk("single_outputs", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++) chk($sformatf("single_order%0d", i), got[i], 32'(i));

    // randomized traffic against the queue model for both variants
    for (int k = 0; k < 600; k++) begin
      v = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             8'($urandom), 32'($urandom), 0, 0, 8'h0, 32'h0, 0);
      cycle(1'b0, v, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
